// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// Upstream valid/ready on the operand side, downstream valid/ready on the result side.
interface fp_mult_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic [W-1:0] dina;
    logic [W-1:0] dinb;
    logic         valid_din;
    logic         ready_din;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         valid_out;
    logic         ready_out;

    modport master (
        output dina, dinb, valid_din, ready_out,
        input  ready_din, result, flags, valid_out
    );

    modport slave (
        input  dina, dinb, valid_din, ready_out,
        output ready_din, result, flags, valid_out
    );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 multiplier with RNE, DAZ/FTZ, exception flags and
// valid/ready backpressure; flags are {invalid, overflow, underflow, inexact}.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic           clk,
    input logic           rstn,
    fp_mult_pipe_if.slave bus
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned XW = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    // Handshake
    logic started_q;
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_load, s2_load, s3_load, accept;

    assign s3_load       = !s3_valid_q || bus.ready_out;
    assign s2_load       = !s2_valid_q || s3_load;
    assign s1_load       = !s1_valid_q || s2_load;
    assign bus.ready_din = started_q && s1_load;
    assign accept        = bus.valid_din && bus.ready_din;

    // S1: unpack and classify
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  fa, fb;
    logic              nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
    logic              sign_d, spec_d;
    logic [W-1:0]      spec_res_d;
    logic [3:0]        spec_flg_d;
    logic signed [XW-1:0] esum;

    assign {sa, ea, fa} = bus.dina;
    assign {sb, eb, fb} = bus.dinb;
    assign nan_a  = (&ea) && (|fa);
    assign nan_b  = (&eb) && (|fb);
    assign snan_a = nan_a && !fa[MAN_W-1];
    assign snan_b = nan_b && !fb[MAN_W-1];
    assign inf_a  = (&ea) && !(|fa);
    assign inf_b  = (&eb) && !(|fb);
    // Zero exponent covers subnormals too: they are treated as signed zero.
    assign zero_a = ~|ea;
    assign zero_b = ~|eb;
    assign sign_d = sa ^ sb;
    assign esum   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    always_comb begin
        spec_d     = 1'b1;
        spec_res_d = '0;
        spec_flg_d = '0;
        if (nan_a || nan_b) begin
            spec_res_d = QNAN;
            spec_flg_d = {snan_a || snan_b, 3'b000};
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            spec_res_d = QNAN;
            spec_flg_d = 4'b1000;
        end else if (inf_a || inf_b) begin
            spec_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a || zero_b) begin
            spec_res_d = {sign_d, {(W - 1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic              s1_sign_q, s1_spec_q;
    logic signed [XW-1:0] s1_exp_q;
    logic [SW-1:0]     s1_ma_q, s1_mb_q;
    logic [W-1:0]      s1_spec_res_q;
    logic [3:0]        s1_spec_flg_q;

    logic              s2_sign_q, s2_spec_q;
    logic signed [XW-1:0] s2_exp_q;
    logic [PW-1:0]     s2_prod_q;
    logic [W-1:0]      s2_spec_res_q;
    logic [3:0]        s2_spec_flg_q;

    // S3: normalise, round, re-normalise, pack
    logic              hi, guard, rest, rnd_up, inexact;
    logic [PW-1:0]     norm;
    logic [SW-1:0]     keep;
    logic [SW:0]       rounded;
    logic [MAN_W-1:0]  frac;
    logic signed [XW-1:0] exp_fin;
    logic [W-1:0]      res_d;
    logic [3:0]        flg_d;

    assign hi      = s2_prod_q[PW-1];
    assign norm    = hi ? s2_prod_q : {s2_prod_q[PW-2:0], 1'b0};
    assign keep    = norm[PW-1:SW];
    assign guard   = norm[MAN_W];
    assign rest    = |norm[MAN_W-1:0];
    assign rnd_up  = guard && (rest || keep[0]);
    assign inexact = guard || rest;
    assign rounded = {1'b0, keep} + {{SW{1'b0}}, rnd_up};
    assign frac    = rounded[SW] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    assign exp_fin = s2_exp_q + $signed({{(XW - 1){1'b0}}, hi})
                              + $signed({{(XW - 1){1'b0}}, rounded[SW]});

    always_comb begin
        res_d = {s2_sign_q, exp_fin[EXP_W-1:0], frac};
        flg_d = {3'b000, inexact};
        if (s2_spec_q) begin
            res_d = s2_spec_res_q;
            flg_d = s2_spec_flg_q;
        end else if (exp_fin >= EMAX) begin
            res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_d = 4'b0101;
        end else if (exp_fin <= EZERO) begin
            res_d = {s2_sign_q, {(W - 1){1'b0}}};
            flg_d = 4'b0011;
        end
    end

    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            started_q     <= 1'b0;
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s3_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_ma_q       <= '0;
            s1_mb_q       <= '0;
            s1_spec_res_q <= '0;
            s1_spec_flg_q <= '0;
            s2_sign_q     <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_exp_q      <= '0;
            s2_prod_q     <= '0;
            s2_spec_res_q <= '0;
            s2_spec_flg_q <= '0;
            result_q      <= '0;
            flags_q       <= '0;
        end else begin
            started_q <= 1'b1;
            if (s1_load) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_sign_q     <= sign_d;
                    s1_spec_q     <= spec_d;
                    s1_exp_q      <= esum;
                    s1_ma_q       <= {1'b1, fa};
                    s1_mb_q       <= {1'b1, fb};
                    s1_spec_res_q <= spec_res_d;
                    s1_spec_flg_q <= spec_flg_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sign_q     <= s1_sign_q;
                    s2_spec_q     <= s1_spec_q;
                    s2_exp_q      <= s1_exp_q;
                    s2_prod_q     <= PW'(s1_ma_q) * PW'(s1_mb_q);
                    s2_spec_res_q <= s1_spec_res_q;
                    s2_spec_flg_q <= s1_spec_flg_q;
                end
            end
            if (s3_load) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    result_q <= res_d;
                    flags_q  <= flg_d;
                end
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.valid_out = s3_valid_q;
endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 binary floating-point multiplier; successor to the fixed fp32 multiplier.
- Exponent and mantissa widths are generic; default is fp32.
- Adds round-to-nearest-even, special-value handling, exception flags, and a valid/ready handshake with output backpressure. Sustains one operation per cycle.
- Sits in the wavelet datapath wherever coefficient × sample products feed the fp adders.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (significand = MAN_W+1 with hidden bit).
- Derived: W = 1+EXP_W+MAN_W, the operand/result width.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- dina  in  W  operand A.
- dinb  in  W  operand B.
- valid_din  in  1  operand pair valid.
- ready_din  out  1  block can accept; a transfer occurs when valid_din && ready_din.
- result  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result.
- valid_out  out  1  result/flags valid.
- ready_out  in  1  downstream accepts; a transfer occurs when valid_out && ready_out.

Behaviour:
- Reset: all stage valid bits 0; result=0, flags=0, valid_out=0. ready_din=1 one cycle after reset release and stays 1 while the pipe is empty.
- Reset asserted mid-operation discards all in-flight operations. No output may appear for them after reset release.
- Pipeline structure: 3 registered stages.
  - S1: unpack, classify, sign XOR, exponent sum ea+eb-bias at EXP_W+2 bits signed.
  - S2: (MAN_W+1)×(MAN_W+1) significand product.
  - S3: normalise, RNE round, re-normalise on carry-out, exception handling, pack. Drives result/flags/valid_out.
- Latency: result valid exactly 3 cycles after the accepting edge, when not stalled.
- Stage advance rule: stage k loads when stage k is empty or stage k+1 advances. S3 holds while valid_out && !ready_out.
- ready_din = !S1_valid || S1_advances. This is combinational from ready_out; no combinational path from valid_din to ready_din.
- Bubbles collapse: with ready_out low, up to 3 operations are accepted before ready_din drops.
- Under backpressure, result and flags are held stable, with no loss, duplication or reordering.
- Subnormal inputs are treated as signed zero (DAZ). Subnormal or too-small results are flushed to signed zero (FTZ).
- Special values, applied in priority order:
  - Any NaN input → canonical qNaN (sign 0, exp all 1s, fraction MSB 1, rest 0). invalid=1 only if an input is sNaN.
  - Inf × 0 → canonical qNaN, invalid=1.
  - Inf × finite nonzero → signed Inf, no flags.
  - Zero × finite → signed zero, no flags.
- Rounding: guard, round and sticky bits are taken from the full product; RNE, ties to an even LSB. inexact=1 when any discarded bit is nonzero.
- Overflow: rounded biased exponent ≥ 2^EXP_W-1 → signed Inf, overflow=1, inexact=1.
- Underflow: rounded biased exponent ≤ 0 with a nonzero product → signed zero, underflow=1, inexact=1.
- Flags are per-result, not sticky.

Test Plan:
- 0x3FC00000 × 0x40000000 → 0x40400000, flags 0000, valid_out exactly 3 cycles after the accept edge.
- 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1. Also 0x3F800003 × 0x3FC00000 (tie) → 0x3FC00004 (even), inexact=1.
- Exceptions:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow+inexact.
  - 0x00800000 × 0x00800000 → 0x00000000, underflow+inexact.
  - 0xFF800000 × 0x40000000 → 0xFF800000, no flags.
- DAZ and sNaN:
  - 0x00000001 × 0x3F800000 → 0x00000000, no flags.
  - 0x7F800001 × 0x3F800000 → 0x7FC00000, invalid=1.
- Backpressure: stream 8 random pairs back-to-back with ready_out held low for cycles 4–9. Required: ready_din drops after 3 accepts; result held stable while stalled; all 8 results match the reference model in order, with no gaps once ready_out is high.
- Reset mid-stream: rstn low for 1 cycle while 3 operations are in flight. Required: valid_out=0 immediately, no stale outputs afterwards. A new operation then completes correctly with latency 3.
- Parameter sweep: rerun the directed vectors with EXP_W=5, MAN_W=10 (fp16). Required: 0x3E00 × 0x4000 → 0x4200; 0x7800 × 0x4000 → 0x7C00 with overflow.
